// File: rtl/ddr2_init_seq.sv
// DDR2 power-up init sequencer: JEDEC command stream to the DIMM, then init_done.
// Define DDR2_INIT_OCD_EN to add the OCD default/exit EMRS1 pair after the final MRS.
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 14
`endif

module ddr2_init_seq #(
  parameter int          T_INIT    = 200,
  parameter int          T_XPR     = 40,
  parameter int          T_RP      = 4,
  parameter int          T_MRD     = 2,
  parameter int          T_RFC     = 26,
  parameter int          T_DLLK    = 200,
  parameter logic [15:0] MR_VALUE  = 16'h0642,
  parameter logic [15:0] EMR_VALUE = 16'h0000
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        cke,
  output logic                        cs_n,
  output logic                        ras_n,
  output logic                        cas_n,
  output logic                        we_n,
  output logic [`DRAM_BA_WIDTH-1:0]   ba,
  output logic [`DRAM_ADDR_WIDTH-1:0] addr,
  output logic                        odt,
  output logic                        init_done
);

  localparam int BW = `DRAM_BA_WIDTH;
  localparam int AW = `DRAM_ADDR_WIDTH;

  localparam logic [AW-1:0] MR_A  = AW'(MR_VALUE);
  localparam logic [AW-1:0] EMR_A = AW'(EMR_VALUE);

  typedef enum logic [3:0] {
    WAIT_INIT,
    CKE_ON,
    PREA1,
    EMRS2,
    EMRS3,
    EMRS1,
    MRS_DLLRST,
    PREA2,
    REF1,
    REF2,
    MRS_FIN,
    OCD_DEF,
    OCD_EXIT,
    WAIT_DLL,
    DONE
  } state_t;

  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] dll_cnt_q, dll_cnt_d;
  logic dll_arm_q, dll_arm_d;
  logic dll_exp;

  logic cke_d, cs_n_d, ras_n_d, cas_n_d, we_n_d, done_d;
  logic [BW-1:0] ba_d;
  logic [AW-1:0] addr_d;

  assign dll_exp = dll_arm_q && (dll_cnt_q == 16'd0);

  // shared spacing counter: loaded on entry, state advances when it hits 0
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (cnt_q != 16'd0) begin
      cnt_d = cnt_q - 16'd1;
    end else begin
      unique case (state_q)
        WAIT_INIT:  state_d = CKE_ON;
        CKE_ON:     state_d = PREA1;
        PREA1:      state_d = EMRS2;
        EMRS2:      state_d = EMRS3;
        EMRS3:      state_d = EMRS1;
        EMRS1:      state_d = MRS_DLLRST;
        MRS_DLLRST: state_d = PREA2;
        PREA2:      state_d = REF1;
        REF1:       state_d = REF2;
        REF2:       state_d = MRS_FIN;
`ifdef DDR2_INIT_OCD_EN
        MRS_FIN:    state_d = OCD_DEF;
`else
        MRS_FIN:    state_d = dll_exp ? DONE : WAIT_DLL;
`endif
        OCD_DEF:    state_d = OCD_EXIT;
        OCD_EXIT:   state_d = dll_exp ? DONE : WAIT_DLL;
        WAIT_DLL:   if (dll_exp) state_d = DONE;
        DONE:       state_d = DONE;
        default:    state_d = WAIT_INIT;
      endcase
    end
    if (state_d != state_q) begin
      unique case (state_d)
        CKE_ON:       cnt_d = 16'(T_XPR - 1);
        PREA1, PREA2: cnt_d = 16'(T_RP - 1);
        REF1, REF2:   cnt_d = 16'(T_RFC - 1);
        EMRS2, EMRS3, EMRS1, MRS_DLLRST,
        MRS_FIN, OCD_DEF, OCD_EXIT:
                      cnt_d = 16'(T_MRD - 1);
        default:      cnt_d = 16'd0;
      endcase
    end
  end

  // DLL lock timer runs alongside the remaining commands
  always_comb begin
    dll_arm_d = dll_arm_q;
    dll_cnt_d = dll_cnt_q;
    if (state_d == MRS_DLLRST && state_q != MRS_DLLRST) begin
      dll_arm_d = 1'b1;
      dll_cnt_d = 16'(T_DLLK - 1);
    end else if (dll_arm_q && dll_cnt_q != 16'd0) begin
      dll_cnt_d = dll_cnt_q - 16'd1;
    end
  end

  // a command goes out only on the first cycle of its state
  always_comb begin
    cke_d   = 1'b1;
    cs_n_d  = 1'b0;
    ras_n_d = 1'b1;
    cas_n_d = 1'b1;
    we_n_d  = 1'b1;
    ba_d    = '0;
    addr_d  = '0;
    done_d  = (state_d == DONE);
    if (state_d == WAIT_INIT) begin
      cke_d  = 1'b0;
      cs_n_d = 1'b1;
    end
    if (state_d != state_q) begin
      unique case (state_d)
        PREA1, PREA2: begin
          ras_n_d    = 1'b0;
          we_n_d     = 1'b0;
          addr_d[10] = 1'b1;
        end
        REF1, REF2: begin
          ras_n_d = 1'b0;
          cas_n_d = 1'b0;
        end
        EMRS2: begin
          {ras_n_d, cas_n_d, we_n_d} = 3'b000;
          ba_d = BW'(2);
        end
        EMRS3: begin
          {ras_n_d, cas_n_d, we_n_d} = 3'b000;
          ba_d = BW'(3);
        end
        EMRS1, OCD_EXIT: begin
          {ras_n_d, cas_n_d, we_n_d} = 3'b000;
          ba_d   = BW'(1);
          addr_d = EMR_A;
        end
        OCD_DEF: begin
          {ras_n_d, cas_n_d, we_n_d} = 3'b000;
          ba_d   = BW'(1);
          addr_d = EMR_A | AW'(16'h0380);
        end
        MRS_DLLRST: begin
          {ras_n_d, cas_n_d, we_n_d} = 3'b000;
          addr_d = MR_A | AW'(16'h0100);
        end
        MRS_FIN: begin
          {ras_n_d, cas_n_d, we_n_d} = 3'b000;
          addr_d = MR_A;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_INIT;
      cnt_q     <= 16'(T_INIT - 1);
      dll_cnt_q <= 16'd0;
      dll_arm_q <= 1'b0;
      cke       <= 1'b0;
      cs_n      <= 1'b1;
      ras_n     <= 1'b1;
      cas_n     <= 1'b1;
      we_n      <= 1'b1;
      ba        <= '0;
      addr      <= '0;
      odt       <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dll_cnt_q <= dll_cnt_d;
      dll_arm_q <= dll_arm_d;
      cke       <= cke_d;
      cs_n      <= cs_n_d;
      ras_n     <= ras_n_d;
      cas_n     <= cas_n_d;
      we_n      <= we_n_d;
      ba        <= ba_d;
      addr      <= addr_d;
      odt       <= 1'b0;
      init_done <= done_d;
    end
  end

endmodule

// File: tb/tb_ddr2_init_seq.sv
// Bench for ddr2_init_seq: cycle checkpoints from a vector table plus
// a command scoreboard built from the timing parameters.
`ifndef DRAM_BA_WIDTH
`define DRAM_BA_WIDTH 3
`endif
`ifndef DRAM_ADDR_WIDTH
`define DRAM_ADDR_WIDTH 14
`endif

module tb_ddr2_init_seq;

  localparam int BW = `DRAM_BA_WIDTH;
  localparam int AW = `DRAM_ADDR_WIDTH;

  localparam int TI   = 200;
  localparam int TX   = 40;
  localparam int TRP  = 4;
  localparam int TMRD = 2;
  localparam int TRFC = 26;
  localparam logic [15:0] MRV  = 16'h0642;
  localparam logic [15:0] EMRV = 16'h0000;

`ifdef DDR2_INIT_OCD_EN
  localparam int N_CMD = 11;
  localparam int F_END = 314;
`else
  localparam int N_CMD = 9;
  localparam int F_END = 310;
`endif

  localparam logic [4:0] DESEL = 5'b01111;
  localparam logic [4:0] NOP   = 5'b10111;
  localparam logic [4:0] PRE   = 5'b10010;
  localparam logic [4:0] MRS   = 5'b10000;
  localparam logic [4:0] REF   = 5'b10001;

  logic clk, rst;
  logic cke, cs_n, ras_n, cas_n, we_n, odt, init_done;
  logic [BW-1:0] ba;
  logic [AW-1:0] addr;
  logic cke1, cs_n1, ras_n1, cas_n1, we_n1, odt1, done1;
  logic [BW-1:0] ba1;
  logic [AW-1:0] addr1;

  int checks = 0;
  int errors = 0;
  int cyc;
  int cmd_seen;
  bit mon_en = 1'b0;
  logic [AW-1:0] last_mr;

  ddr2_init_seq dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n), .ba(ba), .addr(addr), .odt(odt),
    .init_done(init_done)
  );

  ddr2_init_seq #(.T_DLLK(2)) dut_fast (
    .clk(clk), .rst(rst), .cke(cke1), .cs_n(cs_n1), .ras_n(ras_n1),
    .cas_n(cas_n1), .we_n(we_n1), .ba(ba1), .addr(addr1), .odt(odt1),
    .init_done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;

  typedef struct {
    string         name;
    int            cyc;
    logic [4:0]    ctl;
    logic [BW-1:0] ba;
    logic [AW-1:0] addr;
    bit            ad;
    logic          done;
  } vec_t;

  typedef struct {
    int            cyc;
    logic [2:0]    rcw;
    logic [BW-1:0] ba;
    logic [AW-1:0] addr;
    bit            ad;
  } sb_t;

  vec_t vt[$];
  sb_t  sb[$];

  function automatic void add_v(string n, int c, logic [4:0] ctl,
                                int b, int a, bit ad, logic d);
    vec_t v;
    v.name = n;
    v.cyc  = c;
    v.ctl  = ctl;
    v.ba   = BW'(b);
    v.addr = AW'(a);
    v.ad   = ad;
    v.done = d;
    vt.push_back(v);
  endfunction

  function automatic void fill_vectors();
    add_v("reset_state", 0, DESEL, 0, 0, 1, 0);
    add_v("cke_low_last", 199, DESEL, 0, 0, 1, 0);
    add_v("cke_on", 200, NOP, 0, 0, 1, 0);
    add_v("xpr_last", 239, NOP, 0, 0, 1, 0);
    add_v("prea1", 240, PRE, 0, 0, 0, 0);
    add_v("emrs2", 244, MRS, 2, 0, 1, 0);
    add_v("emrs2_gap", 245, NOP, 0, 0, 1, 0);
    add_v("emrs1", 248, MRS, 1, 0, 1, 0);
    add_v("mrs_dllrst", 250, MRS, 0, 'h742, 1, 0);
    add_v("ref1", 256, REF, 0, 0, 0, 0);
    add_v("ref2", 282, REF, 0, 0, 0, 0);
    add_v("mrs_final", 308, MRS, 0, 'h642, 1, 0);
`ifdef DDR2_INIT_OCD_EN
    add_v("ocd_default", 310, MRS, 1, 'h380, 1, 0);
    add_v("ocd_exit", 312, MRS, 1, 0, 1, 0);
`else
    add_v("no_ocd", 310, NOP, 0, 0, 1, 0);
`endif
    add_v("fast_pre", F_END - 1, NOP, 0, 0, 1, 0);
    add_v("fast_done", F_END, NOP, 0, 0, 1, 0);
    add_v("dll_wait", 449, NOP, 0, 0, 1, 0);
    add_v("init_done", 450, NOP, 0, 0, 1, 1);
    add_v("done_hold", 460, NOP, 0, 0, 1, 1);
  endfunction

  function automatic void sb_push(int c, logic [2:0] rcw, int b,
                                  logic [15:0] a, bit ad);
    sb_t e;
    e.cyc  = c;
    e.rcw  = rcw;
    e.ba   = BW'(b);
    e.addr = AW'(a);
    e.ad   = ad;
    sb.push_back(e);
  endfunction

  function automatic void sb_load();
    int c;
    sb.delete();
    cmd_seen = 0;
    last_mr  = '0;
    c = TI + TX;
    sb_push(c, 3'b010, 0, 16'h0, 0); c += TRP;
    sb_push(c, 3'b000, 2, 16'h0, 1); c += TMRD;
    sb_push(c, 3'b000, 3, 16'h0, 1); c += TMRD;
    sb_push(c, 3'b000, 1, EMRV, 1); c += TMRD;
    sb_push(c, 3'b000, 0, MRV | 16'h0100, 1); c += TMRD;
    sb_push(c, 3'b010, 0, 16'h0, 0); c += TRP;
    sb_push(c, 3'b001, 0, 16'h0, 0); c += TRFC;
    sb_push(c, 3'b001, 0, 16'h0, 0); c += TRFC;
    sb_push(c, 3'b000, 0, MRV, 1); c += TMRD;
`ifdef DDR2_INIT_OCD_EN
    sb_push(c, 3'b000, 1, EMRV | 16'h0380, 1); c += TMRD;
    sb_push(c, 3'b000, 1, EMRV, 1);
`endif
  endfunction

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      checks++;
      if (odt !== 1'b0) begin
        errors++;
        $display("FAIL odt cyc=%0d: got %b want 0", cyc, odt);
      end
      if (cs_n === 1'b0 && {ras_n, cas_n, we_n} !== 3'b111) begin
        sb_t e;
        logic ok;
        cmd_seen++;
        checks++;
        if ({ras_n, cas_n, we_n} === 3'b000 && ba === '0) last_mr = addr;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_cmd cyc=%0d: got rcw=%b ba=%0d addr=%h want none",
                   cyc, {ras_n, cas_n, we_n}, ba, addr);
        end else begin
          e = sb.pop_front();
          ok = (e.cyc == cyc) && ({ras_n, cas_n, we_n} === e.rcw);
          if (e.ad) ok = ok && (ba === e.ba) && (addr === e.addr);
          if (e.rcw == 3'b010) ok = ok && (addr[10] === 1'b1);
          if (!ok) begin
            errors++;
            $display("FAIL cmd_order: got cyc=%0d rcw=%b ba=%0d addr=%h want cyc=%0d rcw=%b ba=%0d addr=%h",
                     cyc, {ras_n, cas_n, we_n}, ba, addr, e.cyc, e.rcw, e.ba, e.addr);
          end
        end
      end
    end
  end

  task automatic chk_vec(input int i);
    vec_t v;
    logic ok;
    logic exp_fast;
    v = vt[i];
    exp_fast = (v.cyc >= F_END);
    ok = ({cke, cs_n, ras_n, cas_n, we_n} === v.ctl) &&
         (init_done === v.done) && (done1 === exp_fast);
    if (v.ad) ok = ok && (ba === v.ba) && (addr === v.addr);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s cyc=%0d: got ctl=%b ba=%0d addr=%h done=%b fast=%b want ctl=%b ba=%0d addr=%h done=%b fast=%b",
               v.name, v.cyc, {cke, cs_n, ras_n, cas_n, we_n}, ba, addr,
               init_done, done1, v.ctl, v.ba, v.addr, v.done, exp_fast);
    end
  endtask

  task automatic end_checks();
    checks++;
    if (sb.size() != 0 || cmd_seen != N_CMD) begin
      errors++;
      $display("FAIL cmd_count: got %0d seen, %0d pending want %0d seen, 0 pending",
               cmd_seen, sb.size(), N_CMD);
    end
    checks++;
    if (last_mr[6:4] !== 3'd4 || last_mr[2:0] !== 3'd2) begin
      errors++;
      $display("FAIL dimm_mode: got CL=%0d BL=%0d want CL=4 BL=2", last_mr[6:4], last_mr[2:0]);
    end
  endtask

  task automatic do_run(input int last, input int abort_at);
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    sb_load();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      foreach (vt[i]) if (vt[i].cyc == k) chk_vec(i);
      if (k == abort_at) begin
        #1 rst = 1'b1;
        mon_en = 1'b0;
        #1;
        checks++;
        if ({cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt, init_done} !==
            {DESEL, {BW{1'b0}}, {AW{1'b0}}, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL mid_reset: got ctl=%b ba=%0d addr=%h odt=%b done=%b want ctl=%b ba=0 addr=0 odt=0 done=0",
                   {cke, cs_n, ras_n, cas_n, we_n}, ba, addr, odt, init_done, DESEL);
        end
        return;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    fill_vectors();
    do_run(465, -1);
    end_checks();
    do_run(465, 260);
    do_run(465, -1);
    end_checks();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
